// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver, LSB first. The asynchronous rx line is
//               brought into the clk_50m domain through a two-flop
//               synchronizer. Every decision is made on clken ticks, which
//               arrive at OVERSAMPLE x baud. Start-bit validation happens at
//               the middle of the start bit. Each data bit is captured at its
//               centre. The stop bit is checked at its centre. The received
//               byte is handed over with a rdy / rdy_clr handshake, and the
//               framing and overrun conditions are flagged.
//
// Parameters  : OVERSAMPLE - clken ticks per bit period (even, >= 4)
//
// Ports       : clk_50m   in   system clock
//               rst       in   synchronous active-high reset
//               rx        in   asynchronous serial line, idle high
//               clken     in   one-cycle oversample tick, OVERSAMPLE x baud
//               rdy_clr   in   consumer acknowledge, clears rdy and overrun
//               dout      out  [7:0] last good received byte
//               rdy       out  dout holds an unread byte
//               frame_err out  last frame ended with a low stop bit
//               overrun   out  a good byte was dropped while rdy was set
//               rx_busy   out  receiver is anywhere other than idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       rx,
    input  logic       clken,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_SW = $clog2(OVERSAMPLE);

    // Tick count at which the start bit is re-checked (half a bit period in).
    localparam logic [c_SW-1:0] c_SAMPLE_MID  = c_SW'(OVERSAMPLE / 2 - 1);
    // Tick count marking one full bit period (the next bit centre).
    localparam logic [c_SW-1:0] c_SAMPLE_LAST = c_SW'(OVERSAMPLE - 1);
    localparam logic [c_SW-1:0] c_SAMPLE_ONE  = c_SW'(1);
    localparam logic [c_SW-1:0] c_SAMPLE_ZERO = '0;

    localparam logic [2:0] c_BIT_LAST = 3'd7;

    // Receiver states.
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic            r_rx_meta;
    logic            r_rx_s;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_SW-1:0] r_sample;
    logic [c_SW-1:0] w_sample_nxt;
    logic [2:0]      r_bitpos;
    logic [2:0]      w_bitpos_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;

    logic            w_stop_eval;
    logic            w_frame_good;
    logic            w_frame_bad;

    logic [7:0]      r_dout;
    logic            r_rdy;
    logic            r_frame_err;
    logic            r_overrun;

    // ------------------------------------------------------------------------
    // rx synchronizer. Both flops reset high so that a reset never looks
    // like a start bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register, together with the counters and the
    // shift register whose next values the next-state logic computes.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_sample <= c_SAMPLE_ZERO;
            r_bitpos <= 3'd0;
            r_shift  <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_sample <= w_sample_nxt;
            r_bitpos <= w_bitpos_nxt;
            r_shift  <= w_shift_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic. Nothing moves between clken ticks.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample;
        w_bitpos_nxt = r_bitpos;
        w_shift_nxt  = r_shift;

        if (clken) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt  = c_ST_START;
                        w_sample_nxt = c_SAMPLE_ZERO;
                    end
                end

                c_ST_START: begin
                    if (r_sample == c_SAMPLE_MID) begin
                        // Still low half a bit later: a real start bit.
                        // From here a full bit period lands on each centre.
                        w_sample_nxt = c_SAMPLE_ZERO;
                        if (!r_rx_s) begin
                            w_state_nxt  = c_ST_DATA;
                            w_bitpos_nxt = 3'd0;
                        end else begin
                            // Too short to be a start bit: a glitch.
                            w_state_nxt  = c_ST_IDLE;
                        end
                    end else begin
                        w_sample_nxt = r_sample + c_SAMPLE_ONE;
                    end
                end

                c_ST_DATA: begin
                    if (r_sample == c_SAMPLE_LAST) begin
                        w_sample_nxt          = c_SAMPLE_ZERO;
                        w_shift_nxt[r_bitpos] = r_rx_s;
                        if (r_bitpos == c_BIT_LAST) begin
                            w_state_nxt  = c_ST_STOP;
                        end else begin
                            w_bitpos_nxt = r_bitpos + 3'd1;
                        end
                    end else begin
                        w_sample_nxt = r_sample + c_SAMPLE_ONE;
                    end
                end

                c_ST_STOP: begin
                    if (r_sample == c_SAMPLE_LAST) begin
                        w_sample_nxt = c_SAMPLE_ZERO;
                        // A low stop bit parks the receiver in BREAK so that a
                        // line held low cannot retrigger a new frame.
                        w_state_nxt  = r_rx_s ? c_ST_IDLE : c_ST_BREAK;
                    end else begin
                        w_sample_nxt = r_sample + c_SAMPLE_ONE;
                    end
                end

                c_ST_BREAK: begin
                    if (r_rx_s) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end

                default: begin
                    w_state_nxt  = c_ST_IDLE;
                    w_sample_nxt = c_SAMPLE_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output decode.
    // ------------------------------------------------------------------------
    always_comb begin
        rx_busy      = (r_state != c_ST_IDLE);
        w_stop_eval  = clken && (r_state == c_ST_STOP) && (r_sample == c_SAMPLE_LAST);
        w_frame_good = w_stop_eval &&  r_rx_s;
        w_frame_bad  = w_stop_eval && !r_rx_s;
    end

    // ------------------------------------------------------------------------
    // Handshake and status registers. An acknowledge clears rdy/overrun, but
    // a good frame completing in the same cycle takes precedence: the new
    // byte is delivered and rdy stays set. Because the acknowledge has
    // already cleared overrun, overrun ends up clear in that case.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_dout      <= 8'h00;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (rdy_clr) begin
                r_rdy     <= 1'b0;
                r_overrun <= 1'b0;
            end

            if (w_frame_good) begin
                r_frame_err <= 1'b0;
                if (!r_rdy || rdy_clr) begin
                    r_dout <= r_shift;
                    r_rdy  <= 1'b1;
                end else begin
                    // Consumer has not taken the previous byte; drop this one.
                    r_overrun <= 1'b1;
                end
            end else if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign dout      = r_dout;
    assign rdy       = r_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver. The serial line is
//               driven bit period by bit period, and clken is generated
//               every 27 cycles. A frame-level model tracks what dout, rdy,
//               frame_err, overrun and rx_busy must be. Outputs are compared
//               against the model on each cycle where they are settled, and
//               against literal values at the key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_TICK = 27;           // clk cycles per clken tick
    localparam int c_BIT  = 16 * c_TICK;  // clk cycles per bit period

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic       clken   = 1'b0;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rx        (rx),
        .clken     (clken),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #10 clk_50m = ~clk_50m;

    // clken: one cycle high every c_TICK cycles.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk_50m);
            #1;
            clken = (ph == c_TICK - 1);
            ph    = (ph == c_TICK - 1) ? 0 : ph + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model (frame level)
    // ------------------------------------------------------------------------
    logic [7:0] m_dout;
    logic       m_rdy;
    logic       m_ferr;
    logic       m_ovr;
    logic       m_busy;
    bit         check_en = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void model_reset();
        m_dout = 8'h00;
        m_rdy  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_busy = 1'b0;
    endfunction

    // Outcome of one completed frame; clr = acknowledge in the completion cycle.
    function automatic void model_frame(input logic [7:0] data, input bit good, input bit clr);
        logic old_rdy;
        old_rdy = m_rdy;
        if (clr) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
        if (good) begin
            m_ferr = 1'b0;
            if (!old_rdy || clr) begin
                m_dout = data;
                m_rdy  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
        end
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Continuous comparison while outputs are settled.
    always @(negedge clk_50m) begin
        if (check_en)
            check("cycle_outputs",
                  {4'd0, dout, rdy, frame_err, overrun, rx_busy},
                  {4'd0, m_dout, m_rdy, m_ferr, m_ovr, m_busy});
    end

    task automatic expect_outputs(input string name, input logic [7:0] e_dout, input logic e_rdy,
                                  input logic e_ferr, input logic e_ovr, input logic e_busy);
        @(negedge clk_50m);
        check({name, "_dout"},      16'(dout),      16'(e_dout));
        check({name, "_rdy"},       16'(rdy),       16'(e_rdy));
        check({name, "_frame_err"}, 16'(frame_err), 16'(e_ferr));
        check({name, "_overrun"},   16'(overrun),   16'(e_ovr));
        check({name, "_rx_busy"},   16'(rx_busy),   16'(e_busy));
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk_50m);
        #2;
    endtask

    // Return just after a clken tick has been sampled.
    task automatic align();
        do step(); while (clken !== 1'b1);
        step();
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        step();
        rdy_clr = 1'b0;
        m_rdy   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One full frame starting d cycles after a tick (d <= 20). With clr_done
    // the acknowledge is placed exactly on the completion cycle: the start is
    // seen on the next tick, and completion comes 8 + 9*16 ticks later.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int d, input bit clr_done);
        align();
        repeat (d) step();
        check_en = 1'b0;
        rx       = 1'b0;
        repeat (60) step();
        m_busy   = 1'b1;
        check_en = 1'b1;
        repeat (c_BIT - 60) step();
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (c_BIT) step();
        end
        check_en = 1'b0;
        rx       = stop_ok;
        if (clr_done) begin
            repeat (242 - d) step();
            rdy_clr = 1'b1;
            step();
            rdy_clr = 1'b0;
            repeat (189 + d) step();
        end else begin
            repeat (c_BIT) step();
        end
        model_frame(data, stop_ok, clr_done);
        m_busy   = !stop_ok;
        check_en = 1'b1;
    endtask

    // Hold the line low for nbits after a bad stop bit, then release it.
    task automatic recover_break(input int nbits);
        repeat (nbits * c_BIT) step();
        check_en = 1'b0;
        rx       = 1'b1;
        repeat (60) step();
        m_busy   = 1'b0;
        check_en = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int         d;
        logic [7:0] data;
        bit         good;
        bit         clr;

        model_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) step();
        expect_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_en = 1'b1;

        // Short low pulse: rejected as a glitch.
        align();
        d = int'($urandom_range(20));
        repeat (d) step();
        check_en = 1'b0;
        rx = 1'b0;
        repeat (4 * c_TICK) step();
        rx = 1'b1;
        repeat (c_BIT) step();
        check_en = 1'b1;
        expect_outputs("glitch", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Plain frame.
        send_frame(8'hA5, 1'b1, int'($urandom_range(20)), 1'b0);
        expect_outputs("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();

        // Framing error, line held low, then a good frame.
        send_frame(8'h3C, 1'b0, int'($urandom_range(20)), 1'b0);
        repeat (3 * c_BIT) step();
        expect_outputs("break", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        recover_break(0);
        send_frame(8'h3C, 1'b1, int'($urandom_range(20)), 1'b0);
        expect_outputs("after_break", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();

        // Overrun.
        send_frame(8'h11, 1'b1, int'($urandom_range(20)), 1'b0);
        send_frame(8'h22, 1'b1, int'($urandom_range(20)), 1'b0);
        expect_outputs("overrun", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
        pulse_clr();
        expect_outputs("overrun_clr", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Acknowledge in the completion cycle while rdy is set.
        data = 8'($urandom);
        send_frame(data, 1'b1, int'($urandom_range(20)), 1'b0);
        send_frame(8'h77, 1'b1, int'($urandom_range(20)), 1'b1);
        expect_outputs("clr_same", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of bit 3 of 0xFF.
        align();
        check_en = 1'b0;
        rx = 1'b0;
        repeat (60) step();
        m_busy   = 1'b1;
        check_en = 1'b1;
        repeat (c_BIT - 60) step();
        rx = 1'b1;
        repeat (3 * c_BIT + 200) step();
        check_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_en = 1'b1;
        expect_outputs("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, int'($urandom_range(20)), 1'b0);
        expect_outputs("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized frames.
        for (int i = 0; i < 4; i++) begin
            data = 8'($urandom);
            good = ($urandom_range(4) != 0);
            clr  = ($urandom_range(2) == 0);
            send_frame(data, good, int'($urandom_range(20)), clr);
            if (!good) recover_break(1);
            if ($urandom_range(1) == 1) pulse_clr();
            repeat (50) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
